// File: rtl/multicycle_controller.sv
// Multi-cycle datapath sequencer: decodes op/funct and drives datapath enables/selects per state.
// Latency: instruction takes 2..5 states plus one extra cycle per mem_ready-low wait cycle.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready; all other states ignore it.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_q, state_d;
  logic [2:0] alu_dec;
  logic       pcwrite_c, memwrite_c, irwrite_c, regwrite_c, illegal_c;

  // State register; reset wins over any pending transition, including memory waits.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // ALU operation for R/I-type execute; subtract only for R-type with funct7b5 set.
  always_comb begin
    alu_dec = ALU_ADD;
    unique case (funct3)
      3'b000:  alu_dec = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    immsrc = 2'b00;
    unique case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // Next-state and per-state datapath controls; unlisted selects/enables stay 0.
  always_comb begin
    state_d    = state_q;
    pcwrite_c  = 1'b0;
    adrsrc     = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    illegal_c  = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite_c = mem_ready;
        pcwrite_c = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jump target (OldPC + imm) is computed here into ALUOut.
        alusrca = 2'b01;
        alusrcb = 2'b01;
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc  = 2'b01;
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite_c = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alusrca    = 2'b10;
        alucontrol = alu_dec;
        state_d    = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = alu_dec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alusrca    = 2'b10;
        alucontrol = ALU_SUB;
        pcwrite_c  = zero;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC <- ALUOut (target); ALU forms OldPC + 4 for the link write in ALUWB.
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        pcwrite_c = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural side effects are suppressed while reset is held.
  assign pcwrite    = pcwrite_c  & ~rst;
  assign memwrite   = memwrite_c & ~rst;
  assign irwrite    = irwrite_c  & ~rst;
  assign regwrite   = regwrite_c & ~rst;
  assign illegal_op = illegal_c  & ~rst;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction state sequences with per-cycle output model.
// Latency: inputs driven on falling edge, outputs compared 2 time units later.
// Backpressure: mem_ready waits are injected in FETCH/MEMREAD/MEMWRITE; random elsewhere.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    logic       ill;
  } o_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst, zero, mem_ready, funct7b5;
  logic [6:0] op;
  logic [2:0] funct3;
  logic pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal_op;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  int n_cyc  = 0;
  o_t exp_q[$];

  logic [6:0] nxt_op;
  logic [2:0] nxt_f3;
  logic       nxt_f7, nxt_zero;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .immsrc(immsrc), .alucontrol(alucontrol), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  // Output rules per state written from the control table.
  function automatic o_t expect_o(input logic [3:0] st, input logic [6:0] o,
                                  input logic [2:0] f3, input logic f7,
                                  input logic z, input logic rdy, input logic r);
    o_t e;
    logic [2:0] ad;
    e = '0;
    e.st = st;
    e.imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    case (f3)
      3'b000:  ad = (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  ad = 3'b101;
      3'b110:  ad = 3'b011;
      3'b111:  ad = 3'b010;
      default: ad = 3'b000;
    endcase
    case (st)
      4'd0:  begin e.sb = 2'b10; e.rs = 2'b10; e.irw = rdy; e.pcw = rdy; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01;
                   e.ill = !(o inside {LW, SW, RT, IT, BQ, JL}); end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3:  e.adr = 1'b1;
      4'd4:  begin e.rs = 2'b01; e.rw = 1'b1; end
      4'd5:  begin e.adr = 1'b1; e.mw = 1'b1; end
      4'd6:  begin e.sa = 2'b10; e.alu = ad; end
      4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = ad; end
      4'd8:  e.rw = 1'b1;
      4'd9:  begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; end
      4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      default: ;
    endcase
    if (r) begin
      e.pcw = 1'b0; e.irw = 1'b0; e.rw = 1'b0; e.mw = 1'b0; e.ill = 1'b0;
    end
    return e;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, want);
    end
  endtask

  // One cycle: drive at falling edge and queue the expected outputs for it.
  task automatic cyc(input logic [3:0] st, input logic rdy, input logic r);
    @(negedge clk);
    rst = r; mem_ready = rdy;
    op = nxt_op; funct3 = nxt_f3; funct7b5 = nxt_f7; zero = nxt_zero;
    exp_q.push_back(expect_o(st, op, funct3, funct7b5, zero, rdy, r));
    n_cyc++;
  endtask

  // Whole instruction expressed as its state path; fw/mw = wait cycles in fetch/memory.
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input int fw, input int mw, output int n);
    n_cyc = 0;
    nxt_op = o; nxt_f3 = f3; nxt_f7 = f7; nxt_zero = z;
    for (int i = 0; i < fw; i++) cyc(4'd0, 1'b0, 1'b0);
    cyc(4'd0, 1'b1, 1'b0);
    cyc(4'd1, rnd(), 1'b0);
    case (o)
      LW: begin
        cyc(4'd2, rnd(), 1'b0);
        for (int i = 0; i < mw; i++) cyc(4'd3, 1'b0, 1'b0);
        cyc(4'd3, 1'b1, 1'b0);
        cyc(4'd4, rnd(), 1'b0);
      end
      SW: begin
        cyc(4'd2, rnd(), 1'b0);
        for (int i = 0; i < mw; i++) cyc(4'd5, 1'b0, 1'b0);
        cyc(4'd5, 1'b1, 1'b0);
      end
      RT: begin cyc(4'd6, rnd(), 1'b0); cyc(4'd8, rnd(), 1'b0); end
      IT: begin cyc(4'd7, rnd(), 1'b0); cyc(4'd8, rnd(), 1'b0); end
      BQ: cyc(4'd9, rnd(), 1'b0);
      JL: begin cyc(4'd10, rnd(), 1'b0); cyc(4'd8, rnd(), 1'b0); end
      default: ;
    endcase
    n = n_cyc;
  endtask

  // Single compare process: every queued cycle checked against the DUT outputs.
  always @(negedge clk) begin
    o_t e, a;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
           alusrca, alusrcb, immsrc, alucontrol, illegal_op};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle st=%0d op=%b got=%h expected=%h", e.st, op, a, e);
      end
    end
  end

  initial begin
    int n;
    o_t p;
    rst = 1'b1; mem_ready = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
    nxt_op = '0; nxt_f3 = '0; nxt_f7 = 1'b0; nxt_zero = 1'b0;

    // Literal pins on the model itself.
    p = expect_o(4'd6, RT, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0); chk("pin_add_alu", p.alu, 0);
    p = expect_o(4'd6, RT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0); chk("pin_sub_alu", p.alu, 1);
    p = expect_o(4'd7, IT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0); chk("pin_addi_alu", p.alu, 0);
    p = expect_o(4'd9, BQ, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0); chk("pin_beq_imm", p.imm, 2);
    p = expect_o(4'd10, JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0); chk("pin_jal_imm", p.imm, 3);
    p = expect_o(4'd4, LW, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0); chk("pin_memwb_rs", p.rs, 1);

    // Power-up reset: state unknown for the first cycles, then FETCH with enables off.
    @(negedge clk); @(negedge clk);
    cyc(4'd0, 1'b1, 1'b1);

    run(RT, 3'b000, 1'b0, 1'b0, 0, 0, n); chk("len_add", n, 4);
    run(RT, 3'b000, 1'b1, 1'b0, 0, 0, n); chk("len_sub", n, 4);
    run(RT, 3'b110, 1'b0, 1'b0, 0, 0, n);
    run(RT, 3'b111, 1'b1, 1'b0, 0, 0, n);
    run(IT, 3'b010, 1'b0, 1'b0, 0, 0, n); chk("len_slti", n, 4);
    run(IT, 3'b000, 1'b1, 1'b0, 1, 0, n); chk("len_addi_wait", n, 5);
    run(IT, 3'b001, 1'b0, 1'b0, 0, 0, n);
    run(LW, 3'b010, 1'b0, 1'b0, 0, 0, n); chk("len_lw", n, 5);
    run(LW, 3'b010, 1'b0, 1'b0, 0, 3, n); chk("len_lw_wait3", n, 8);
    run(SW, 3'b010, 1'b0, 1'b0, 0, 0, n); chk("len_sw", n, 4);
    run(SW, 3'b010, 1'b0, 1'b0, 2, 2, n); chk("len_sw_wait", n, 8);
    run(BQ, 3'b000, 1'b0, 1'b1, 0, 0, n); chk("len_beq_taken", n, 3);
    run(BQ, 3'b000, 1'b0, 1'b0, 0, 0, n); chk("len_beq_not", n, 3);
    run(JL, 3'b000, 1'b0, 1'b0, 0, 0, n); chk("len_jal", n, 4);
    run(BAD, 3'b000, 1'b0, 1'b0, 0, 0, n); chk("len_illegal", n, 2);

    // Reset held two cycles while MEMWRITE waits on memory, then sw resumes from FETCH.
    nxt_op = SW; nxt_f3 = 3'b010; nxt_f7 = 1'b0; nxt_zero = 1'b0;
    cyc(4'd0, 1'b1, 1'b0);
    cyc(4'd1, 1'b0, 1'b0);
    cyc(4'd2, 1'b0, 1'b0);
    cyc(4'd5, 1'b0, 1'b0);
    cyc(4'd5, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b1);
    run(SW, 3'b010, 1'b0, 1'b0, 0, 0, n);
    run(RT, 3'b000, 1'b0, 1'b0, 0, 0, n);

    @(negedge clk);
    #3;
    chk("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
